// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: streams an image into byte-addressed IM, zero-fills the tail,
// then releases the core. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int unsigned IM_BYTES = 64,
  parameter int unsigned AW       = $clog2(IM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [7:0]    im_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  localparam int unsigned CW    = AW + 1;
  localparam int unsigned MAX_N = IM_BYTES / 4;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_CHK  = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] end_q, end_d;
  logic          s_ready_q, s_ready_d;
  logic          im_we_q, im_we_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [7:0]    im_wdata_q, im_wdata_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          xfer_c;
  logic [CW-1:0] cnt_inc_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  assign xfer_c    = s_valid & s_ready_q;
  assign cnt_inc_c = cnt_q + CW'(1);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HDR;
      cnt_q      <= '0;
      end_q      <= '0;
      s_ready_q  <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= 8'h00;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      end_q      <= end_d;
      s_ready_q  <= s_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  // Next-state, write generation and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    end_d      = end_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    case (state_q)
      ST_HDR: begin
        if (xfer_c) begin
          if ((s_data == 8'd0) || (s_data > 8'(MAX_N))) begin
            state_d = ST_ERR;
          end else begin
            end_d   = CW'({s_data, 2'b00});
            cnt_d   = '0;
            state_d = ST_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d   = 8'h00;
`endif
          end
        end
      end

      ST_LOAD: begin
        if (xfer_c) begin
          im_we_d    = 1'b1;
          im_addr_d  = cnt_q[AW-1:0];
          im_wdata_d = s_data;
          cnt_d      = cnt_inc_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ s_data;
          if (cnt_inc_c == end_q) state_d = ST_CHK;
`else
          if (cnt_inc_c == end_q) state_d = ST_FILL;
`endif
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer_c) state_d = (s_data == xor_q) ? ST_FILL : ST_ERR;
      end
`endif

      // A full image reaches here with cnt at IM_BYTES and leaves without writing
      ST_FILL: begin
        if (cnt_q == CW'(IM_BYTES)) begin
          state_d = ST_DONE;
        end else begin
          im_we_d    = 1'b1;
          im_addr_d  = cnt_q[AW-1:0];
          im_wdata_d = 8'h00;
          cnt_d      = cnt_inc_c;
        end
      end

      ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR;
          cnt_d   = '0;
        end
      end

      default: state_d = ST_ERR;
    endcase

    s_ready_d = (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_CHK);
    cpu_rst_d = (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
  end

  assign s_ready  = s_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header checks, load/fill contents, gaps, mid-load reset, restart.
module tb_imem_loader;

  localparam int unsigned IM_BYTES = 64;
  localparam int unsigned AW       = 6;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data  = 8'h00;
  logic          s_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [7:0]    im_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [IM_BYTES];
  logic [7:0] exp_mem [IM_BYTES];
  int   we_cnt      = 0;
  logic we_prev     = 1'b0;
  logic done_prev   = 1'b0;
  logic done_gap_ok = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.IM_BYTES(IM_BYTES), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  // IM model; done must rise in a cycle without a write, right after one with a write
  always @(posedge clk) begin
    if (im_we === 1'b1) begin
      mem[im_addr] <= im_wdata;
      we_cnt       <= we_cnt + 1;
    end
    if (done === 1'b1 && done_prev === 1'b0) done_gap_ok <= we_prev & ~im_we;
    we_prev   <= im_we;
    done_prev <= done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < IM_BYTES; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < IM_BYTES; i++) exp_mem[i] = 8'h00;
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was accepted
  task automatic send(input logic [7:0] b);
    int g = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("send_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {31'd0, (done === 1'b1 || err === 1'b1)}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] pl2 [8];
    logic [7:0] b;
    logic [7:0] x;
    pl2[0] = 8'h8B; pl2[1] = 8'h02; pl2[2] = 8'h00; pl2[3] = 8'h20;
    pl2[4] = 8'hCB; pl2[5] = 8'h03; pl2[6] = 8'h00; pl2[7] = 8'h41;

    // Reset held with a valid byte on the stream
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h02;
    repeat (3) @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_im_we",   {31'd0, im_we},   32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_err",     {31'd0, err},     32'd0);
    check("rst_im_addr", 32'(im_addr),     32'd0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    check("rdy_before_edge", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    check("rdy_after_edge", {31'd0, s_ready}, 32'd1);
    check("rst_no_writes", 32'(we_cnt), 32'd0);

    // N=2 image, tail zero-filled
    base = we_cnt;
    clear_exp();
    send(8'h02);
    for (int i = 0; i < 8; i++) begin
      send(pl2[i]);
      exp_mem[i] = pl2[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h20);
`endif
    wait_end(200);
    @(negedge clk);
    check("n2_done",     {31'd0, done},    32'd1);
    check("n2_err",      {31'd0, err},     32'd0);
    check("n2_cpu_rst",  {31'd0, cpu_rst}, 32'd0);
    check("n2_s_ready",  {31'd0, s_ready}, 32'd0);
    check("n2_im_we",    {31'd0, im_we},   32'd0);
    check("n2_we_count", 32'(we_cnt - base), 32'd64);
    check_mem("n2_mem");
    check("n2_done_gap", {31'd0, done_gap_ok}, 32'd1);

    pulse_start();
    check("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("restart_done",    {31'd0, done},    32'd0);
    check("restart_s_ready", {31'd0, s_ready}, 32'd1);

    // Header 0 is rejected
    base = we_cnt;
    send(8'h00);
    check("h00_err",     {31'd0, err},     32'd1);
    check("h00_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("h00_s_ready", {31'd0, s_ready}, 32'd0);
    check("h00_done",    {31'd0, done},    32'd0);
    repeat (3) @(negedge clk);
    check("h00_err_sticky", {31'd0, err}, 32'd1);
    check("h00_no_writes",  32'(we_cnt - base), 32'd0);
    pulse_start();
    check("h00_restart_err",   {31'd0, err},     32'd0);
    check("h00_restart_ready", {31'd0, s_ready}, 32'd1);

    // Header one above capacity is rejected
    base = we_cnt;
    send(8'd17);
    check("h17_err",     {31'd0, err},     32'd1);
    check("h17_s_ready", {31'd0, s_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("h17_no_writes", 32'(we_cnt - base), 32'd0);
    pulse_start();

    // Full image with stream gaps: no fill writes
    base = we_cnt;
    x = 8'h00;
    send(8'd16);
    for (int i = 0; i < 64; i++) begin
      b = 8'(i * 7 + 3);
      exp_mem[i] = b;
      x = x ^ b;
      send(b);
      if (i % 4 == 0) repeat (2) @(negedge clk);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(x);
`endif
    wait_end(300);
    @(negedge clk);
    check("n16_done",     {31'd0, done}, 32'd1);
    check("n16_we_count", 32'(we_cnt - base), 32'd64);
    check_mem("n16_mem");
    check("n16_done_gap", {31'd0, done_gap_ok}, 32'd1);

    // Reset asserted partway through a payload
    pulse_start();
    send(8'h01);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    rst_n = 1'b0;
    #1;
    check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("midrst_im_we",   {31'd0, im_we},   32'd0);
    check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = we_cnt;
    clear_exp();
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33; exp_mem[3] = 8'h44;
    send(8'h01);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h44);
`endif
    wait_end(200);
    @(negedge clk);
    check("n1_done",     {31'd0, done},    32'd1);
    check("n1_cpu_rst",  {31'd0, cpu_rst}, 32'd0);
    check("n1_we_count", 32'(we_cnt - base), 32'd64);
    check_mem("n1_mem");
    pulse_start();
    check("n1_restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("n1_restart_done",    {31'd0, done},    32'd0);
    check("n1_restart_ready",   {31'd0, s_ready}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum mismatch stops before fill
    base = we_cnt;
    send(8'h01);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h45);
    wait_end(50);
    check("chk_bad_err",  {31'd0, err},  32'd1);
    check("chk_bad_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("chk_bad_writes", 32'(we_cnt - base), 32'd4);
    pulse_start();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
